rom_port_arbiter: RTL and testbench

- Shares the single-port synchronous instruction ROM IP between the IF-stage fetch port and the MEM-stage load port of the openriscv core inside openriscv_min_sopc.
- Serialises accesses, waits out the ROM's read latency and returns the data to the owning requester.
- Raises per-port stall requests that feed the pipeline ctrl unit.
- Only one access is in flight at any time.

---
 rtl/rom_port_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Arbitrates the IF fetch port and MEM load port onto one synchronous instruction ROM, one access at a time.
// Define ROM_ARB_RR_EN for round-robin arbitration on contention; otherwise mem has fixed priority over if.
module rom_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned ROM_AW  = 10,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_valid,
    input  logic              mem_req,
    input  logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_rdata,
    output logic              mem_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              rom_ce,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_data
);

    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_d;
    logic              owner;
    logic              owner_d;
    logic              winner_c;
    logic              rom_ce_d;
    logic [ROM_AW-1:0] rom_addr_d;
    logic [DW-1:0]     if_rdata_d;
    logic [DW-1:0]     mem_rdata_d;
    logic              if_valid_d;
    logic              mem_valid_d;

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[AW-1:ROM_AW+2],
                                mem_addr[1:0], mem_addr[AW-1:ROM_AW+2]};

    // owner: 1 = mem port, 0 = if port; also serves as the last-owner flag.
`ifdef ROM_ARB_RR_EN
    assign winner_c = (if_req & mem_req) ? ~owner : mem_req;
`else
    assign winner_c = mem_req;
`endif

    // Stalls drop as soon as reset asserts so the pipeline sees all-zero outputs.
    assign stall_if  = if_req  & ~if_valid  & ~rst;
    assign stall_mem = mem_req & ~mem_valid & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (if_req | mem_req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt;
        owner_d     = owner;
        rom_ce_d    = 1'b0;
        rom_addr_d  = rom_addr;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (if_req | mem_req) begin
                    owner_d    = winner_c;
                    rom_ce_d   = 1'b1;
                    rom_addr_d = winner_c ? mem_addr[ROM_AW+1:2] : if_addr[ROM_AW+1:2];
                end
            end
            ISSUE: cnt_d = CW'(ROM_LAT - 1);
            WAIT: begin
                if (cnt == '0) begin
                    if (owner) begin
                        mem_rdata_d = rom_data;
                        mem_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = rom_data;
                        if_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            owner     <= 1'b0;
            rom_ce    <= 1'b0;
            rom_addr  <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            owner     <= owner_d;
            rom_ce    <= rom_ce_d;
            rom_addr  <= rom_addr_d;
            if_rdata  <= if_rdata_d;
            mem_rdata <= mem_rdata_d;
            if_valid  <= if_valid_d;
            mem_valid <= mem_valid_d;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: ROM_LAT=1 instance with a ROM model and scoreboard,
// plus a ROM_LAT=3 instance for the long-latency load case.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req;
    logic [31:0] if_addr, mem_addr;
    logic [31:0] if_rdata, mem_rdata, rom_data;
    logic        if_valid, mem_valid, stall_if, stall_mem, rom_ce;
    logic [9:0]  rom_addr;

    logic        d3_if_req, d3_mem_req;
    logic [31:0] d3_if_addr, d3_mem_addr;
    logic [31:0] d3_if_rdata, d3_mem_rdata, d3_rom_data;
    logic        d3_if_valid, d3_mem_valid, d3_stall_if, d3_stall_mem, d3_rom_ce;
    logic [9:0]  d3_rom_addr;

    logic [31:0] rom [0:1023];
    logic [31:0] p1;
    logic [31:0] p3 [3];
    logic [31:0] q_if[$];
    logic [31:0] q_mem[$];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic        if_r;
        logic        mem_r;
        logic [31:0] ia;
        logic [31:0] ma;
        int          exp_if;
        int          exp_mem;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    rom_port_arbiter #(.AW(32), .DW(32), .ROM_AW(10), .ROM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    rom_port_arbiter #(.AW(32), .DW(32), .ROM_AW(10), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(d3_if_req), .if_addr(d3_if_addr), .if_rdata(d3_if_rdata), .if_valid(d3_if_valid),
        .mem_req(d3_mem_req), .mem_addr(d3_mem_addr), .mem_rdata(d3_mem_rdata), .mem_valid(d3_mem_valid),
        .stall_if(d3_stall_if), .stall_mem(d3_stall_mem),
        .rom_ce(d3_rom_ce), .rom_addr(d3_rom_addr), .rom_data(d3_rom_data)
    );

    // ROM models: data appears exactly ROM_LAT cycles after the rom_ce cycle, garbage otherwise.
    always @(posedge clk) begin
        p1    <= rom_ce ? rom[rom_addr] : 32'hDEADBEEF;
        p3[0] <= d3_rom_ce ? rom[d3_rom_addr] : 32'hDEADBEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rom_data    = p1;
    assign d3_rom_data = p3[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return rom[a[11:2]];
    endfunction

    // Scoreboard: every valid pulse must match the oldest expectation for that port.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_valid) begin
                if (q_if.size() == 0) check("sb_if_unexpected_valid", 32'(if_valid), 32'd0);
                else check("sb_if_rdata", if_rdata, q_if.pop_front());
                check("sb_both_valid", 32'(mem_valid), 32'd0);
            end
            if (mem_valid) begin
                if (q_mem.size() == 0) check("sb_mem_unexpected_valid", 32'(mem_valid), 32'd0);
                else check("sb_mem_rdata", mem_rdata, q_mem.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic single_fetch();
        if_addr = 32'h14;
        if_req  = 1'b1;
        q_if.push_back(32'h00500093);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t1_rom_ce_c%0d", c), 32'(rom_ce), 32'(c == 1));
            if (c == 1) check("t1_rom_addr", 32'(rom_addr), 32'd5);
            check($sformatf("t1_stall_if_c%0d", c), 32'(stall_if), 32'(c < 3));
            check($sformatf("t1_if_valid_c%0d", c), 32'(if_valid), 32'(c == 3));
            check($sformatf("t1_mem_valid_c%0d", c), 32'(mem_valid), 32'd0);
            if (c == 3) check("t1_if_rdata", if_rdata, 32'h00500093);
            tick();
        end
        if_req = 1'b0;
    endtask

    task automatic contention();
        if_addr  = 32'h0;
        mem_addr = 32'h8;
        q_mem.push_back(rom[2]);
        q_if.push_back(rom[0]);
        if_req  = 1'b1;
        mem_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t2_mem_valid_c%0d", c), 32'(mem_valid), 32'(c == 3));
            check($sformatf("t2_if_valid_c%0d", c), 32'(if_valid), 32'(c == 7));
            check($sformatf("t2_stall_if_c%0d", c), 32'(stall_if), 32'(c < 7));
            check($sformatf("t2_rom_ce_c%0d", c), 32'(rom_ce), 32'(c == 1 || c == 5));
            if (c == 3) check("t2_mem_rdata", mem_rdata, rom[2]);
            if (c == 7) check("t2_if_rdata", if_rdata, rom[0]);
            tick();
            if (c == 3) mem_req = 1'b0;
        end
        if_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit if_done;
        bit mem_done;
        if_done  = !v.if_r;
        mem_done = !v.mem_r;
        if_addr  = v.ia;
        mem_addr = v.ma;
        if (v.if_r)  q_if.push_back(exp_word(v.ia));
        if (v.mem_r) q_mem.push_back(exp_word(v.ma));
        if_req  = v.if_r;
        mem_req = v.mem_r;
        for (int c = 0; c < 30 && !(if_done && mem_done); c++) begin
            @(negedge clk);
            if (if_valid && !if_done) begin
                check($sformatf("vec%0d_if_cycle", idx), 32'(c), 32'(v.exp_if));
                if_done = 1'b1;
            end
            if (mem_valid && !mem_done) begin
                check($sformatf("vec%0d_mem_cycle", idx), 32'(c), 32'(v.exp_mem));
                mem_done = 1'b1;
            end
            tick();
            if (if_done)  if_req  = 1'b0;
            if (mem_done) mem_req = 1'b0;
        end
        check($sformatf("vec%0d_completed", idx), 32'({if_done, mem_done}), 32'd3);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic stream_test();
        bit exp_mem[4];
        int k;
        int drop_after;
`ifdef ROM_ARB_RR_EN
        exp_mem    = '{1'b1, 1'b0, 1'b1, 1'b0};
        drop_after = 4;
`else
        exp_mem    = '{1'b1, 1'b1, 1'b1, 1'b0};
        drop_after = 3;
`endif
        if_addr  = 32'h10;
        mem_addr = 32'h18;
        for (int i = 0; i < 4; i++) begin
            if (exp_mem[i]) q_mem.push_back(rom[6]);
            else            q_if.push_back(rom[4]);
        end
        if_req  = 1'b1;
        mem_req = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (if_valid || mem_valid) begin
                check($sformatf("stream%0d_port", k), 32'(mem_valid), 32'(exp_mem[k]));
                check($sformatf("stream%0d_cycle", k), 32'(c), 32'(3 + 4 * k));
                k++;
            end
            tick();
            if (k >= drop_after) mem_req = 1'b0;
            if (k >= 4)          if_req  = 1'b0;
        end
        check("stream_count", 32'(k), 32'd4);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    task automatic held_req();
        if_addr = 32'h14;
        q_if.push_back(rom[5]);
        q_if.push_back(rom[5]);
        if_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("t5_rom_ce_c%0d", c), 32'(rom_ce), 32'(c == 1 || c == 5));
            check($sformatf("t5_if_valid_c%0d", c), 32'(if_valid), 32'(c == 3 || c == 7));
            tick();
        end
        if_req = 1'b0;
    endtask

    task automatic long_latency();
        d3_mem_addr = 32'h40;
        d3_mem_req  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t6_rom_ce_c%0d", c), 32'(d3_rom_ce), 32'(c == 1));
            if (c == 1) check("t6_rom_addr", 32'(d3_rom_addr), 32'd16);
            check($sformatf("t6_mem_valid_c%0d", c), 32'(d3_mem_valid), 32'(c == 5));
            check($sformatf("t6_stall_mem_c%0d", c), 32'(d3_stall_mem), 32'(c < 5));
            check($sformatf("t6_if_valid_c%0d", c), 32'(d3_if_valid), 32'd0);
            if (c == 5) check("t6_mem_rdata", d3_mem_rdata, rom[16]);
            tick();
        end
        d3_mem_req = 1'b0;
    endtask

    task automatic reset_mid_access();
        if_addr = 32'h100;
        if_req  = 1'b1;
        gap(2);
        rst = 1'b1;
        #1;
        check("t7_rst_rom_ce", 32'(rom_ce), 32'd0);
        check("t7_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("t7_rst_if_valid", 32'(if_valid), 32'd0);
        check("t7_rst_stall_if", 32'(stall_if), 32'd0);
        check("t7_rst_if_rdata", if_rdata, 32'd0);
        check("t7_rst_mem_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        check("t7_rst_hold_if_valid", 32'(if_valid), 32'd0);
        tick();
        rst = 1'b0;
        q_if.push_back(rom[64]);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            check($sformatf("t7_rom_ce_r%0d", r), 32'(rom_ce), 32'(r == 1));
            check($sformatf("t7_if_valid_r%0d", r), 32'(if_valid), 32'(r == 3));
            tick();
            if (r == 3) if_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0001;
        rom[5] = 32'h00500093;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          3, -1};
        vecs[1] = '{1'b0, 1'b1, 32'h0,          32'h0000_0FFC, -1, 3};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFF_F017, 32'h0,          3, -1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0033, 7, 3};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0004, 32'h8000_0006, 7, 3};
        vecs[5] = '{1'b0, 1'b1, 32'h0,          32'h0000_0044, -1, 3};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          3, -1};

        rst = 1'b1;
        if_req = 1'b1; mem_req = 1'b0; if_addr = 32'h0; mem_addr = 32'h0;
        d3_if_req = 1'b0; d3_mem_req = 1'b0; d3_if_addr = 32'h0; d3_mem_addr = 32'h0;
        gap(2);
        @(negedge clk);
        check("reset_rom_ce", 32'(rom_ce), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_mem_valid", 32'(mem_valid), 32'd0);
        check("reset_if_rdata", if_rdata, 32'd0);
        check("reset_stall_if", 32'(stall_if), 32'd0);
        tick();
        if_req = 1'b0;
        rst = 1'b0;
        gap(2);

        single_fetch();
        gap(2);
        contention();
        gap(2);
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            gap(2);
        end
        stream_test();
        gap(2);
        held_req();
        gap(2);
        long_latency();
        gap(2);
        reset_mid_access();
        gap(3);

        check("sb_if_drained", 32'(q_if.size()), 32'd0);
        check("sb_mem_drained", 32'(q_mem.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
